// File: rtl/card_map_ctrl_pkg.sv
// Shared display definitions for the card map controller: geometry, op codes,
// requester ids and FSM states.
package card_map_ctrl_pkg;

  localparam int ROWS   = 8;
  localparam int COLS   = 18;
  localparam int SLOTS  = ROWS * COLS;
  localparam int TYPE_W = 6;
  localparam int POS_W  = 8;

  localparam logic [POS_W-1:0]  SLOT_LAST  = 8'(SLOTS - 1);
  localparam logic [TYPE_W-1:0] CARD_EMPTY = '0;

  localparam logic [1:0] OP_WRITE   = 2'd0;
  localparam logic [1:0] OP_TOGGLE  = 2'd1;
  localparam logic [1:0] OP_CLR_SEL = 2'd2;
  localparam logic [1:0] OP_MOVE    = 2'd3;

  typedef enum logic {
    REQ_LOC = 1'b0,
    REQ_REM = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MOVE2,
    ST_ACK
  } state_e;

  function automatic logic slot_ok(input logic [POS_W-1:0] idx);
    return idx <= SLOT_LAST;
  endfunction

endpackage

// File: rtl/card_map_ctrl_if.sv
// Request/ack bundle between the local and remote requesters and the card map
// controller; master is the requester side, slave is the controller.
interface card_map_ctrl_if;
  import card_map_ctrl_pkg::*;

  logic              loc_req;
  logic [1:0]        loc_op;
  logic [POS_W-1:0]  loc_pos;
  logic [POS_W-1:0]  loc_dst;
  logic [TYPE_W-1:0] loc_card;
  logic              loc_ack;

  logic              rem_req;
  logic [1:0]        rem_op;
  logic [POS_W-1:0]  rem_pos;
  logic [POS_W-1:0]  rem_dst;
  logic [TYPE_W-1:0] rem_card;
  logic              rem_ack;

  logic              err;

  modport master (
    output loc_req, loc_op, loc_pos, loc_dst, loc_card,
    output rem_req, rem_op, rem_pos, rem_dst, rem_card,
    input  loc_ack, rem_ack, err
  );

  modport slave (
    input  loc_req, loc_op, loc_pos, loc_dst, loc_card,
    input  rem_req, rem_op, rem_pos, rem_dst, rem_card,
    output loc_ack, rem_ack, err
  );

endinterface

// File: rtl/card_req_arb.sv
// Two-way round-robin arbiter gated by v_blank; a side whose ack is currently
// pulsing is masked so a just-finished request cannot be re-granted.
module card_req_arb
  import card_map_ctrl_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    v_blank,
  input  logic    enable,
  input  logic    loc_req,
  input  logic    rem_req,
  input  logic    loc_block,
  input  logic    rem_block,
  output logic    grant,
  output req_id_e grant_id
);

  req_id_e ptr_q, ptr_d;
  logic    loc_ok, rem_ok;

  always_comb begin
    loc_ok   = loc_req && !loc_block;
    rem_ok   = rem_req && !rem_block;
    grant    = enable && v_blank && (loc_ok || rem_ok);
    ptr_d    = ptr_q;
    grant_id = REQ_LOC;
    if (loc_ok && rem_ok) begin
      grant_id = ptr_q;
    end else if (rem_ok) begin
      grant_id = REQ_REM;
    end
    // Pointer only moves on a contested grant, handing priority to the loser.
    if (grant && loc_ok && rem_ok) begin
      ptr_d = (ptr_q == REQ_LOC) ? REQ_REM : REQ_LOC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= REQ_LOC;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/card_map_ctrl.sv
// Card map and selection mask owner: arbitrates local/remote slot updates and
// commits them one at a time, only starting new work during vertical blanking.
module card_map_ctrl
  import card_map_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     v_blank,
  card_map_ctrl_if.slave           bus,
  output logic                     busy,
  output logic [SLOTS*TYPE_W-1:0]  map,
  output logic [SLOTS-1:0]         sel_card
);

  state_e                          state_q, state_d;
  logic [1:0]                      op_q, op_d;
  logic [POS_W-1:0]                pos_q, pos_d;
  logic [POS_W-1:0]                dst_q, dst_d;
  logic [TYPE_W-1:0]               card_q, card_d;
  req_id_e                         id_q, id_d;
  logic                            rej_q, rej_d;
  logic [SLOTS-1:0][TYPE_W-1:0]    map_q, map_d;
  logic [SLOTS-1:0]                sel_q, sel_d;
  logic                            loc_ack_q, loc_ack_d;
  logic                            rem_ack_q, rem_ack_d;
  logic                            err_q, err_d;
  logic                            grant;
  req_id_e                         grant_id;

  card_req_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .v_blank   (v_blank),
    .enable    (state_q == ST_IDLE),
    .loc_req   (bus.loc_req),
    .rem_req   (bus.rem_req),
    .loc_block (loc_ack_q),
    .rem_block (rem_ack_q),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    pos_d     = pos_q;
    dst_d     = dst_q;
    card_d    = card_q;
    id_d      = id_q;
    rej_d     = rej_q;
    map_d     = map_q;
    sel_d     = sel_q;
    loc_ack_d = 1'b0;
    rem_ack_d = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          id_d    = grant_id;
          rej_d   = 1'b0;
          state_d = ST_EXEC;
          if (grant_id == REQ_REM) begin
            op_d   = bus.rem_op;
            pos_d  = bus.rem_pos;
            dst_d  = bus.rem_dst;
            card_d = bus.rem_card;
          end else begin
            op_d   = bus.loc_op;
            pos_d  = bus.loc_pos;
            dst_d  = bus.loc_dst;
            card_d = bus.loc_card;
          end
        end
      end

      ST_EXEC: begin
        state_d = ST_ACK;
        case (op_q)
          OP_WRITE: begin
            if (!slot_ok(pos_q)) rej_d = 1'b1;
            else                 map_d[pos_q] = card_q;
          end
          OP_TOGGLE: begin
            if (!slot_ok(pos_q)) rej_d = 1'b1;
            else                 sel_d[pos_q] = ~sel_q[pos_q];
          end
          OP_CLR_SEL: begin
            sel_d = '0;
          end
          default: begin
            // A self-move is a legal no-op; it must skip MOVE2 or the card is lost.
            if (!slot_ok(pos_q) || !slot_ok(dst_q)) begin
              rej_d = 1'b1;
            end else if (pos_q == dst_q) begin
              rej_d = 1'b0;
            end else if (map_q[pos_q] == CARD_EMPTY) begin
              rej_d = 1'b1;
            end else if (map_q[dst_q] != CARD_EMPTY) begin
              rej_d = 1'b1;
            end else begin
              map_d[dst_q] = map_q[pos_q];
              sel_d[dst_q] = 1'b0;
              state_d      = ST_MOVE2;
            end
          end
        endcase
      end

      ST_MOVE2: begin
        map_d[pos_q] = CARD_EMPTY;
        sel_d[pos_q] = 1'b0;
        state_d      = ST_ACK;
      end

      default: begin
        loc_ack_d = (id_q == REQ_LOC);
        rem_ack_d = (id_q == REQ_REM);
        err_d     = rej_q;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_WRITE;
      pos_q     <= '0;
      dst_q     <= '0;
      card_q    <= '0;
      id_q      <= REQ_LOC;
      rej_q     <= 1'b0;
      map_q     <= '0;
      sel_q     <= '0;
      loc_ack_q <= 1'b0;
      rem_ack_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      pos_q     <= pos_d;
      dst_q     <= dst_d;
      card_q    <= card_d;
      id_q      <= id_d;
      rej_q     <= rej_d;
      map_q     <= map_d;
      sel_q     <= sel_d;
      loc_ack_q <= loc_ack_d;
      rem_ack_q <= rem_ack_d;
      err_q     <= err_d;
    end
  end

  assign bus.loc_ack = loc_ack_q;
  assign bus.rem_ack = rem_ack_q;
  assign bus.err     = err_q;
  assign busy        = (state_q != ST_IDLE);
  assign map         = map_q;
  assign sel_card    = sel_q;

endmodule

// File: tb/tb_card_map_ctrl.sv
// Directed bench for card_map_ctrl: each task drives one scenario and checks
// the results against hand-computed values.
module tb_card_map_ctrl;
  import card_map_ctrl_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    v_blank;
  logic                    busy;
  logic [SLOTS*TYPE_W-1:0] map;
  logic [SLOTS-1:0]        sel_card;

  card_map_ctrl_if bus();

  card_map_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .v_blank  (v_blank),
    .bus      (bus.slave),
    .busy     (busy),
    .map      (map),
    .sel_card (sel_card)
  );

  int n_compared;
  int n_mismatched;

  logic [TYPE_W-1:0] exp_map [SLOTS];
  logic [SLOTS-1:0]  exp_sel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [SLOTS*TYPE_W-1:0] flat_map();
    logic [SLOTS*TYPE_W-1:0] f;
    for (int i = 0; i < SLOTS; i++) f[i*TYPE_W +: TYPE_W] = exp_map[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < SLOTS; i++) exp_map[i] = '0;
    exp_sel = '0;
  endtask

  task automatic issue(input bit rem, input logic [1:0] op, input logic [7:0] pos,
                       input logic [7:0] dst, input logic [5:0] card);
    if (rem) begin
      bus.rem_op = op; bus.rem_pos = pos; bus.rem_dst = dst; bus.rem_card = card;
      bus.rem_req = 1'b1;
    end else begin
      bus.loc_op = op; bus.loc_pos = pos; bus.loc_dst = dst; bus.loc_card = card;
      bus.loc_req = 1'b1;
    end
  endtask

  // Counts falling edges until the wanted ack shows up, then drops that req.
  task automatic wait_ack(input bit want_rem, output int cycles, output bit seen,
                          output bit other_seen, output logic err_v);
    cycles = 0; seen = 1'b0; other_seen = 1'b0; err_v = 1'bx;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      cycles++;
      if ((want_rem ? bus.rem_ack : bus.loc_ack) === 1'b1) begin
        seen  = 1'b1;
        err_v = bus.err;
      end else if ((want_rem ? bus.loc_ack : bus.rem_ack) === 1'b1) begin
        other_seen = 1'b1;
      end
    end
    if (want_rem) bus.rem_req = 1'b0;
    else          bus.loc_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    model_clear();
    n_compared++;
    if (map !== flat_map()) begin
      n_mismatched++; $display("[TB] FAIL reset_map: got %h required 0", map);
    end
    n_compared++;
    if (sel_card !== '0) begin
      n_mismatched++; $display("[TB] FAIL reset_sel: got %h required 0", sel_card);
    end
    n_compared++;
    if ({bus.loc_ack, bus.rem_ack, bus.err, busy} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ctl: got %b required 0000", {bus.loc_ack, bus.rem_ack, bus.err, busy});
    end
  endtask

  task automatic test_write();
    int cyc; bit seen, other; logic e;
    issue(0, OP_WRITE, 8'd5, 8'd0, 6'h1A);
    @(negedge clk);
    n_compared++;
    if (busy !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL write_busy: got %b required 1", busy);
    end
    wait_ack(0, cyc, seen, other, e);
    cyc++;
    exp_map[5] = 6'h1A;
    n_compared++;
    if (!seen || cyc != 3) begin
      n_mismatched++; $display("[TB] FAIL write_latency: seen=%0d got %0d edges required 3", seen, cyc);
    end
    n_compared++;
    if (e !== 1'b0 || bus.rem_ack !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL write_err: err=%b rem_ack=%b required 0/0", e, bus.rem_ack);
    end
    n_compared++;
    if (map[35:30] !== 6'h1A) begin
      n_mismatched++; $display("[TB] FAIL write_slot5: got %h required 1a", map[35:30]);
    end
    n_compared++;
    if (map !== flat_map()) begin
      n_mismatched++; $display("[TB] FAIL write_map: got %h required %h", map, flat_map());
    end
    @(negedge clk);
    n_compared++;
    if (bus.loc_ack !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL write_ack_pulse: got %b required 0", bus.loc_ack);
    end
  endtask

  task automatic test_both_req();
    int cyc; bit seen, other; logic e;
    issue(0, OP_WRITE, 8'd10, 8'd0, 6'h11);
    issue(1, OP_WRITE, 8'd11, 8'd0, 6'h22);
    wait_ack(0, cyc, seen, other, e);
    n_compared++;
    if (!seen || other || cyc != 3) begin
      n_mismatched++; $display("[TB] FAIL rr_first_loc: seen=%0d rem_first=%0d edges=%0d required 1/0/3", seen, other, cyc);
    end
    wait_ack(1, cyc, seen, other, e);
    n_compared++;
    if (!seen || cyc != 3) begin
      n_mismatched++; $display("[TB] FAIL rr_then_rem: seen=%0d edges=%0d required 1/3", seen, cyc);
    end
    exp_map[10] = 6'h11; exp_map[11] = 6'h22;
    @(negedge clk);
    issue(0, OP_WRITE, 8'd12, 8'd0, 6'h13);
    issue(1, OP_WRITE, 8'd13, 8'd0, 6'h24);
    wait_ack(1, cyc, seen, other, e);
    n_compared++;
    if (!seen || other || cyc != 3) begin
      n_mismatched++; $display("[TB] FAIL rr_second_rem: seen=%0d loc_first=%0d edges=%0d required 1/0/3", seen, other, cyc);
    end
    wait_ack(0, cyc, seen, other, e);
    n_compared++;
    if (!seen || cyc != 3) begin
      n_mismatched++; $display("[TB] FAIL rr_then_loc: seen=%0d edges=%0d required 1/3", seen, cyc);
    end
    exp_map[12] = 6'h13; exp_map[13] = 6'h24;
    n_compared++;
    if (map !== flat_map()) begin
      n_mismatched++; $display("[TB] FAIL rr_map: got %h required %h", map, flat_map());
    end
    @(negedge clk);
  endtask

  task automatic test_vblank_gate();
    int cyc, bad; bit seen, other; logic e;
    v_blank = 1'b0;
    bad = 0;
    issue(1, OP_WRITE, 8'd0, 8'd0, 6'h05);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || bus.rem_ack !== 1'b0 || bus.loc_ack !== 1'b0) bad++;
    end
    n_compared++;
    if (bad != 0) begin
      n_mismatched++; $display("[TB] FAIL vblank_hold: got %0d active cycles required 0", bad);
    end
    v_blank = 1'b1;
    wait_ack(1, cyc, seen, other, e);
    exp_map[0] = 6'h05;
    n_compared++;
    if (!seen || cyc != 3 || e !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL vblank_release: seen=%0d edges=%0d err=%b required 1/3/0", seen, cyc, e);
    end
    n_compared++;
    if (map !== flat_map()) begin
      n_mismatched++; $display("[TB] FAIL vblank_map: got %h required %h", map, flat_map());
    end
    @(negedge clk);
  endtask

  task automatic test_move();
    int cyc; bit seen, other; logic e;
    issue(0, OP_WRITE, 8'd3, 8'd0, 6'h07);
    wait_ack(0, cyc, seen, other, e);
    @(negedge clk);
    issue(0, OP_TOGGLE, 8'd3, 8'd0, 6'h00);
    wait_ack(0, cyc, seen, other, e);
    @(negedge clk);
    issue(1, OP_TOGGLE, 8'd20, 8'd0, 6'h00);
    wait_ack(1, cyc, seen, other, e);
    @(negedge clk);
    exp_map[3] = 6'h07; exp_sel[3] = 1'b1; exp_sel[20] = 1'b1;
    n_compared++;
    if (sel_card !== exp_sel || map !== flat_map()) begin
      n_mismatched++; $display("[TB] FAIL move_setup: sel %h required %h", sel_card, exp_sel);
    end
    issue(0, OP_MOVE, 8'd3, 8'd20, 6'h00);
    @(negedge clk);
    v_blank = 1'b0;
    wait_ack(0, cyc, seen, other, e);
    cyc++;
    v_blank = 1'b1;
    exp_map[20] = 6'h07; exp_map[3] = 6'h00; exp_sel[3] = 1'b0; exp_sel[20] = 1'b0;
    n_compared++;
    if (!seen || cyc != 4 || e !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL move_latency: seen=%0d edges=%0d err=%b required 1/4/0", seen, cyc, e);
    end
    n_compared++;
    if (map[125:120] !== 6'h07 || map[23:18] !== 6'h00) begin
      n_mismatched++; $display("[TB] FAIL move_slots: map20=%h map3=%h required 07/00", map[125:120], map[23:18]);
    end
    n_compared++;
    if (sel_card !== exp_sel || map !== flat_map()) begin
      n_mismatched++; $display("[TB] FAIL move_state: sel %h required %h", sel_card, exp_sel);
    end
    @(negedge clk);
  endtask

  task automatic test_errors();
    int cyc; bit seen, other; logic e;
    logic [1:0] ops  [5];
    logic [7:0] poss [5];
    logic [7:0] dsts [5];
    logic       errs [5];
    ops[0] = OP_WRITE;  poss[0] = 8'd150; dsts[0] = 8'd0;   errs[0] = 1'b1;
    ops[1] = OP_MOVE;   poss[1] = 8'd50;  dsts[1] = 8'd51;  errs[1] = 1'b1;
    ops[2] = OP_MOVE;   poss[2] = 8'd5;   dsts[2] = 8'd20;  errs[2] = 1'b1;
    ops[3] = OP_MOVE;   poss[3] = 8'd5;   dsts[3] = 8'd200; errs[3] = 1'b1;
    ops[4] = OP_MOVE;   poss[4] = 8'd5;   dsts[4] = 8'd5;   errs[4] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      issue(k[0], ops[k], poss[k], dsts[k], 6'h3F);
      wait_ack(k[0], cyc, seen, other, e);
      n_compared++;
      if (!seen || cyc != 3 || e !== errs[k]) begin
        n_mismatched++;
        $display("[TB] FAIL err_case%0d: seen=%0d edges=%0d err=%b required 1/3/%b", k, seen, cyc, e, errs[k]);
      end
      n_compared++;
      if (map !== flat_map() || sel_card !== exp_sel) begin
        n_mismatched++; $display("[TB] FAIL err_unchanged%0d: map %h required %h", k, map, flat_map());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_toggle_clr();
    int cyc; bit seen, other; logic e;
    issue(0, OP_TOGGLE, 8'd143, 8'd0, 6'h00);
    wait_ack(0, cyc, seen, other, e);
    n_compared++;
    if (sel_card[143] !== 1'b1 || e !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL toggle143_on: got %b err=%b required 1/0", sel_card[143], e);
    end
    @(negedge clk);
    issue(1, OP_TOGGLE, 8'd143, 8'd0, 6'h00);
    wait_ack(1, cyc, seen, other, e);
    n_compared++;
    if (sel_card[143] !== 1'b0) begin
      n_mismatched++; $display("[TB] FAIL toggle143_off: got %b required 0", sel_card[143]);
    end
    @(negedge clk);
    issue(0, OP_TOGGLE, 8'd1, 8'd0, 6'h00);   wait_ack(0, cyc, seen, other, e); @(negedge clk);
    issue(1, OP_TOGGLE, 8'd2, 8'd0, 6'h00);   wait_ack(1, cyc, seen, other, e); @(negedge clk);
    issue(0, OP_TOGGLE, 8'd100, 8'd0, 6'h00); wait_ack(0, cyc, seen, other, e); @(negedge clk);
    exp_sel = '0; exp_sel[1] = 1'b1; exp_sel[2] = 1'b1; exp_sel[100] = 1'b1;
    n_compared++;
    if (sel_card !== exp_sel) begin
      n_mismatched++; $display("[TB] FAIL toggle_multi: got %h required %h", sel_card, exp_sel);
    end
    issue(1, OP_CLR_SEL, 8'd200, 8'd0, 6'h00);
    wait_ack(1, cyc, seen, other, e);
    exp_sel = '0;
    n_compared++;
    if (sel_card !== exp_sel || e !== 1'b0 || map !== flat_map()) begin
      n_mismatched++; $display("[TB] FAIL clr_sel: got %h err=%b required 0/0", sel_card, e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int acks;
    issue(0, OP_MOVE, 8'd5, 8'd60, 6'h00);
    @(negedge clk);
    n_compared++;
    if (busy !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL midop_busy: got %b required 1", busy);
    end
    rst = 1'b1;
    bus.loc_req = 1'b0;
    @(negedge clk);
    model_clear();
    n_compared++;
    if (map !== flat_map() || sel_card !== exp_sel ||
        {bus.loc_ack, bus.rem_ack, bus.err, busy} !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL midop_reset: ctl=%b map5=%h required 0000/00",
               {bus.loc_ack, bus.rem_ack, bus.err, busy}, map[35:30]);
    end
    rst = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.loc_ack !== 1'b0 || bus.rem_ack !== 1'b0 || busy !== 1'b0) acks++;
    end
    n_compared++;
    if (acks != 0) begin
      n_mismatched++; $display("[TB] FAIL midop_no_ack: got %0d active cycles required 0", acks);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst          = 1'b1;
    v_blank      = 1'b1;
    bus.loc_req  = 1'b0; bus.loc_op = '0; bus.loc_pos = '0; bus.loc_dst = '0; bus.loc_card = '0;
    bus.rem_req  = 1'b0; bus.rem_op = '0; bus.rem_pos = '0; bus.rem_dst = '0; bus.rem_card = '0;
    model_clear();
    test_reset();
    test_write();
    test_both_req();
    test_vblank_gate();
    test_move();
    test_errors();
    test_toggle_clr();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/card_map_ctrl.md
Name: card_map_ctrl

Overview:
- Owns the card map (144 slots × 6-bit card type) and the 144-bit selected-card mask that feed the card renderer.
- Arbitrates slot-update requests from two requesters, local (player input FSM) and remote (inter-board link), and executes them one at a time.
- Commits updates only during vertical blanking, so a displayed frame never shows a half-applied update.
- Sits between the game-logic/link blocks and the display path.

Parameters:
- SLOTS, 144, number of map slots (8 rows × 18 columns, index 0..143).
- TYPE_W, 6, card-type width; type 0 means empty slot.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- v_blank  in  1  high while the VGA is outside the visible area; sampled on clk.
- loc_req  in  1  local request; level, held until loc_ack.
- loc_op  in  2  local op code: 0 WRITE, 1 TOGGLE, 2 CLR_SEL, 3 MOVE.
- loc_pos  in  8  local source/target slot index.
- loc_dst  in  8  local destination slot, MOVE only.
- loc_card  in  6  local card type, WRITE only.
- loc_ack  out  1  one-cycle completion pulse to local.
- rem_req, rem_op, rem_pos, rem_dst, rem_card  in  1/2/8/8/6  remote request, same meaning as the local fields.
- rem_ack  out  1  one-cycle completion pulse to remote.
- err  out  1  valid with either ack; 1 = request rejected, state unchanged.
- busy  out  1  high in any state other than IDLE.
- map  out  864  slot i type at bits [i*6+5 : i*6].
- sel_card  out  144  bit i = slot i selected.

Behaviour:
- Reset (synchronous, rst=1 at clk edge): map=0, sel_card=0, loc_ack=rem_ack=err=busy=0, state=IDLE, round-robin pointer=local.
- FSM states: IDLE, EXEC, MOVE2, ACK.
- IDLE → EXEC:
  - Grant happens only when v_blank=1 and at least one req is high.
  - If only one req is high, grant it.
  - If both are high, grant the side the pointer names; the pointer then flips to the other side.
  - On the grant edge, latch op, pos, dst, card and the granted id.
- EXEC actions (1 cycle):
  - WRITE: map[pos] ← card. Card 0 is legal and clears the slot.
  - TOGGLE: sel_card[pos] ← ~sel_card[pos].
  - CLR_SEL: sel_card ← 0; pos is ignored.
  - MOVE: map[dst] ← map[pos]; sel_card[dst] ← 0; go to MOVE2.
  - All other ops go to ACK.
- MOVE2 (1 cycle): map[pos] ← 0; sel_card[pos] ← 0; go to ACK.
- ACK (1 cycle):
  - Pulse the granted side's ack and drive err.
  - The other ack stays 0.
  - Go to IDLE.
- Rejection (checked in EXEC on the latched fields): set err=1, make no state change, go straight to ACK. Reject when:
  - pos > 143 (all ops except CLR_SEL);
  - MOVE with dst > 143;
  - MOVE with map[pos]==0;
  - MOVE with map[dst]!=0 and dst!=pos.
- MOVE with pos==dst: no change, err=0.
- Latency from grant edge to ack high: 2 cycles for WRITE/TOGGLE/CLR_SEL/errors, 3 cycles for a valid MOVE.
- Requester contract: hold req and fields stable until ack is seen, then drop req the same cycle.
  - The IDLE cycle after ACK grants nothing from a req that was just acked (1-cycle gap).
  - The other side may be granted in that cycle.
- v_blank falling mid-operation: the operation runs to completion. Grants resume only when v_blank=1.
- rst mid-operation: immediate return to reset values, no ack issued, and the latched request is discarded.
- map and sel_card are registered outputs; each updates on the clk edge of the state that writes it.

Decomposition:
- Shared display package holds:
  - op-code constants OP_WRITE=0, OP_TOGGLE=1, OP_CLR_SEL=2, OP_MOVE=3;
  - SLOTS=144, ROWS=8, COLS=18, TYPE_W=6;
  - CARD_EMPTY=0.
- One sub-module is natural: card_req_arb, the two-way round-robin arbiter with v_blank gating, grant id and pointer.
- Map storage, bounds checks and the FSM stay in card_map_ctrl.

Test Plan:
- Reset, then loc WRITE pos=5 card=0x1A with v_blank=1 → loc_ack 2 cycles after grant, err=0; map[35:30]=0x1A; other slots 0.
- loc and rem both request in the same IDLE cycle after reset → local granted first, rem_ack follows after local's ack.
  - Repeat with both requesting again → remote is granted first.
- Request with v_blank=0 for 100 cycles → busy=0, no ack; v_blank rises → grant next edge, ack 2 cycles later.
- MOVE pos=3→dst=20 with map[3]=0x07, sel_card[3]=1 → ack after 3 cycles; map[20]=0x07, map[3]=0, sel_card[3]=0, sel_card[20]=0.
- Error cases, each → ack with err=1 and map/sel_card unchanged:
  - WRITE pos=150;
  - MOVE from an empty slot;
  - MOVE onto an occupied slot.
- TOGGLE pos=143 twice → sel_card[143] goes 1 then 0; CLR_SEL with several bits set → sel_card=0.
- rst asserted in EXEC of a MOVE → next cycle all outputs at reset values, no ack pulse.
